// File: rtl/mcp3x08_pkg.sv
// Shared types, SPI command bit positions and helpers for the MCP3x08 scan master.
package mcp3x08_pkg;

   typedef enum logic [1:0] {IDLE, XFER, FINISH, CSH_WAIT} state_t;

   // Rising-edge index (1-based) of each command bit and of the ADC null bit
   localparam int START_SCK_IDX = 1;
   localparam int SGL_SCK_IDX   = 2;
   localparam int D2_SCK_IDX    = 3;
   localparam int D1_SCK_IDX    = 4;
   localparam int D0_SCK_IDX    = 5;
   localparam int NULL_SCK_IDX  = 7;

   function automatic int frame_len(input int data_w);
      return 7 + data_w;
   endfunction

   function automatic logic cmd_bit(input int idx, input logic diff, input logic [2:0] ch,
                                    input int num_ch);
      logic b;
      b = 1'b0;
      case (idx)
         START_SCK_IDX: b = 1'b1;
         SGL_SCK_IDX:   b = ~diff;
         D2_SCK_IDX:    b = (num_ch == 8) ? ch[2] : 1'b0;
         D1_SCK_IDX:    b = ch[1];
         D0_SCK_IDX:    b = ch[0];
         default:       b = 1'b0;
      endcase
      return b;
   endfunction

   // Lowest set channel at or above 'from'; bit 3 of the result flags a hit
   function automatic logic [3:0] find_ch(input logic [7:0] mask, input logic [3:0] from);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         if (mask[i] && (i >= int'(from))) r = {1'b1, 3'(i)};
      end
      return r;
   endfunction

endpackage

// File: rtl/spi_sck_strobe.sv
// SCK generator: toggles every CLK_DIV clks while enabled, idles low; rise/fall strobes
// mark the cycle whose closing edge moves SCK. No backpressure; disabling resets phase.
module spi_sck_strobe #(
   parameter int CLK_DIV = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic sck_o,
   output logic rise_o,
   output logic fall_o
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt_q;
   logic          sck_q;
   logic          tick_d;

   assign tick_d = en_i && (cnt_q == CW'(CLK_DIV - 1));
   assign rise_o = tick_d && !sck_q;
   assign fall_o = tick_d && sck_q;
   assign sck_o  = sck_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         sck_q <= 1'b0;
      end else if (!en_i) begin
         cnt_q <= '0;
         sck_q <= 1'b0;
      end else if (tick_d) begin
         cnt_q <= '0;
         sck_q <= ~sck_q;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/mcp3x08_scan_master.sv
// SPI scan master for MCP3004/3008/3204/3208: one tagged result per enabled channel every
// 2*CLK_DIV*(7+DATA_W)+1+CSH_CYCLES clks, no backpressure; MCP3X08_NULL_CHECK_EN adds null_err.
module mcp3x08_scan_master
   import mcp3x08_pkg::*;
#(
   parameter int CLK_DIV    = 8,
   parameter int DATA_W     = 10,
   parameter int NUM_CH     = 8,
   parameter int CSH_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              scan_cont,
   input  logic [NUM_CH-1:0] chan_mask,
   input  logic              diff_mode,
   output logic              busy,
   output logic [DATA_W-1:0] data_out,
   output logic [2:0]        data_ch,
   output logic              data_valid,
   output logic              scan_done,
   output logic              null_err,
   input  logic              MISO,
   output logic              MOSI,
   output logic              SCK,
   output logic              CS_n
);
   localparam int FRAME_LEN = frame_len(DATA_W);
   localparam int CSH_W     = $clog2(CSH_CYCLES + 1);

   state_t            state_q;
   logic [7:0]        mask_q;
   logic              diff_q;
   logic [2:0]        ch_q;
   logic [4:0]        bit_q;
   logic [CSH_W-1:0]  csh_q;
   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] data_out_q;
   logic [2:0]        data_ch_q;
   logic              cs_n_q, mosi_q, busy_q, dv_q, done_q;
   logic              sck_rise, sck_fall;

   logic [7:0] mask_in_d;
   logic [3:0] first_in_d, first_d, next_d;
   logic [4:0] bit_nx_d;

   assign mask_in_d  = 8'(chan_mask);
   assign first_in_d = find_ch(mask_in_d, 4'd0);
   assign first_d    = find_ch(mask_q, 4'd0);
   assign next_d     = find_ch(mask_q, {1'b0, ch_q} + 4'd1);
   assign bit_nx_d   = bit_q + 5'd1;

   spi_sck_strobe #(.CLK_DIV(CLK_DIV)) u_sck (
      .clk    (clk),
      .rst    (rst),
      .en_i   (state_q == XFER),
      .sck_o  (SCK),
      .rise_o (sck_rise),
      .fall_o (sck_fall)
   );

`ifdef MCP3X08_NULL_CHECK_EN
   logic null_q, nerr_q;
   assign null_err = nerr_q;
`else
   assign null_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         mask_q     <= '0;
         diff_q     <= 1'b0;
         ch_q       <= '0;
         bit_q      <= '0;
         csh_q      <= '0;
         shift_q    <= '0;
         data_out_q <= '0;
         data_ch_q  <= '0;
         cs_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         busy_q     <= 1'b0;
         dv_q       <= 1'b0;
         done_q     <= 1'b0;
`ifdef MCP3X08_NULL_CHECK_EN
         null_q     <= 1'b0;
         nerr_q     <= 1'b0;
`endif
      end else begin
         dv_q   <= 1'b0;
         done_q <= 1'b0;
`ifdef MCP3X08_NULL_CHECK_EN
         nerr_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (start && (chan_mask != '0)) begin
                  mask_q  <= mask_in_d;
                  diff_q  <= diff_mode;
                  ch_q    <= first_in_d[2:0];
                  busy_q  <= 1'b1;
                  cs_n_q  <= 1'b0;
                  mosi_q  <= 1'b1;
                  bit_q   <= '0;
                  state_q <= XFER;
               end
            end
            XFER: begin
               if (sck_rise) begin
                  bit_q <= bit_nx_d;
                  if (bit_nx_d > 5'(NULL_SCK_IDX)) shift_q <= {shift_q[DATA_W-2:0], MISO};
`ifdef MCP3X08_NULL_CHECK_EN
                  if (bit_nx_d == 5'(NULL_SCK_IDX)) null_q <= MISO;
`endif
               end
               if (sck_fall) begin
                  // Falling edge after the last rise closes the frame
                  if (bit_q == 5'(FRAME_LEN)) begin
                     state_q    <= FINISH;
                     cs_n_q     <= 1'b1;
                     mosi_q     <= 1'b0;
                     dv_q       <= 1'b1;
                     done_q     <= ~next_d[3];
                     data_out_q <= shift_q;
                     data_ch_q  <= ch_q;
`ifdef MCP3X08_NULL_CHECK_EN
                     nerr_q     <= null_q;
`endif
                  end else begin
                     mosi_q <= cmd_bit(int'(bit_q) + 1, diff_q, ch_q, NUM_CH);
                  end
               end
            end
            FINISH: begin
               csh_q   <= '0;
               state_q <= CSH_WAIT;
            end
            CSH_WAIT: begin
               if (csh_q == CSH_W'(CSH_CYCLES - 1)) begin
                  if (next_d[3] || scan_cont) begin
                     ch_q    <= next_d[3] ? next_d[2:0] : first_d[2:0];
                     cs_n_q  <= 1'b0;
                     mosi_q  <= 1'b1;
                     bit_q   <= '0;
                     state_q <= XFER;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end else begin
                  csh_q <= csh_q + CSH_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy       = busy_q;
   assign data_out   = data_out_q;
   assign data_ch    = data_ch_q;
   assign data_valid = dv_q;
   assign scan_done  = done_q;
   assign MOSI       = mosi_q;
   assign CS_n       = cs_n_q;

endmodule

// File: tb/tb_mcp3x08_scan_master.sv
// Bench for mcp3x08_scan_master: two configurations (10-bit/8-ch, 12-bit/4-ch) with an ADC slave model.
module tb_mcp3x08_scan_master;

   logic clk = 1'b0;
   logic rst;
   logic [1:0] start, scan_cont, diff_mode, busy, dv, done, nerr, mosi, sck, cs_n;
   logic [1:0] miso = 2'b00;
   logic [7:0] mask_a;
   logic [3:0] mask_b;
   logic [9:0] dout_a;
   logic [11:0] dout_b;
   logic [2:0] dch_a, dch_b;

   always #5 clk = ~clk;

   mcp3x08_scan_master #(.CLK_DIV(8), .DATA_W(10), .NUM_CH(8), .CSH_CYCLES(16)) u_a (
      .clk(clk), .rst(rst), .start(start[0]), .scan_cont(scan_cont[0]), .chan_mask(mask_a),
      .diff_mode(diff_mode[0]), .busy(busy[0]), .data_out(dout_a), .data_ch(dch_a),
      .data_valid(dv[0]), .scan_done(done[0]), .null_err(nerr[0]),
      .MISO(miso[0]), .MOSI(mosi[0]), .SCK(sck[0]), .CS_n(cs_n[0]));

   mcp3x08_scan_master #(.CLK_DIV(2), .DATA_W(12), .NUM_CH(4), .CSH_CYCLES(3)) u_b (
      .clk(clk), .rst(rst), .start(start[1]), .scan_cont(scan_cont[1]), .chan_mask(mask_b),
      .diff_mode(diff_mode[1]), .busy(busy[1]), .data_out(dout_b), .data_ch(dch_b),
      .data_valid(dv[1]), .scan_done(done[1]), .null_err(nerr[1]),
      .MISO(miso[1]), .MOSI(mosi[1]), .SCK(sck[1]), .CS_n(cs_n[1]));

   typedef struct { logic [31:0] cmd; int rises; int low; int gap; } frame_t;
   typedef struct { logic [11:0] data; logic [2:0] ch; logic done; logic nerr; } res_t;
   typedef struct {
      int d; logic [7:0] mask; logic diff; logic [11:0] val; logic nb;
      int frames; int first_ch; int last_ch; logic [11:0] exp_data;
   } vec_t;

   frame_t frq[$];
   res_t   rq[$];
   logic [11:0] resp [2][8];
   logic null_bit = 1'b0;
   int n_cmp = 0, n_bad = 0, stray = 0;

   int rise_k[2], low_c[2], high_c[2], gap_l[2];
   logic [31:0] cmd_w[2];
   logic [2:0] ch_l[2];
   logic sck_p[2]  = '{1'b0, 1'b0};
   logic cs_p[2]   = '{1'b1, 1'b1};
   logic mosi_p[2] = '{1'b0, 1'b0};

   // ADC slave: MISO for rise k is presented before that rise and changes after SCK falls
   function automatic logic slave_bit(input int d, input int k);
      int w;
      w = (d == 1) ? 12 : 10;
      if (k == 7) return null_bit;
      if (k >= 8 && k <= 7 + w) return resp[d][ch_l[d]][w - 1 - (k - 8)];
      return 1'($urandom_range(0, 1));
   endfunction

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!cs_n[d] && cs_p[d]) begin
            gap_l[d] = high_c[d]; rise_k[d] = 0; low_c[d] = 0; cmd_w[d] = '0;
            miso[d] = slave_bit(d, 1);
         end
         if (cs_n[d] && !cs_p[d]) begin
            frq.push_back('{cmd_w[d], rise_k[d], low_c[d], gap_l[d]});
            high_c[d] = 0;
         end
         if (!cs_n[d]) begin
            if (sck[d] && !sck_p[d]) begin
               rise_k[d]++;
               cmd_w[d] = {cmd_w[d][30:0], mosi_p[d]};
               if (rise_k[d] == 5) ch_l[d] = cmd_w[d][2:0];
            end
            if (!sck[d] && sck_p[d]) miso[d] = slave_bit(d, rise_k[d] + 1);
         end
         if (cs_n[d]) high_c[d]++; else low_c[d]++;
         sck_p[d] = sck[d]; cs_p[d] = cs_n[d]; mosi_p[d] = mosi[d];
         if (!dv[d] && (done[d] || nerr[d])) stray++;
      end
      if (dv[0]) rq.push_back('{{2'b00, dout_a}, dch_a, done[0], nerr[0]});
      if (dv[1]) rq.push_back('{dout_b, dch_b, done[1], nerr[1]});
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_scan(input int d, input logic [7:0] m, input logic df, input logic cont);
      @(negedge clk);
      if (d == 0) mask_a = m; else mask_b = m[3:0];
      diff_mode[d] = df; scan_cont[d] = cont; start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
      chk("busy_after_start", busy[d], 1);
      chk("csn_after_start", cs_n[d], 0);
   endtask

   task automatic wait_idle(input int d, input int budget);
      int n;
      n = 0;
      while (busy[d] && n < budget) begin @(negedge clk); n++; end
      chk("idle_timeout", busy[d], 0);
      repeat (3) @(negedge clk);
   endtask

   // Reference: channels visited in ascending order of the mask, nscans times
   task automatic check_run(input int d, input logic [7:0] m, input logic df, input int nscans);
      int nch, w, fl, cd, csh, last, n;
      frame_t f; res_t r;
      logic [2:0] ech; logic [31:0] ecmd; logic [11:0] edat; logic enerr;
      nch = (d == 1) ? 4 : 8; w = (d == 1) ? 12 : 10; fl = w + 7;
      cd = (d == 1) ? 2 : 8; csh = (d == 1) ? 3 : 16;
      last = -1; n = 0;
      for (int c = 0; c < nch; c++) if (m[c]) last = c;
`ifdef MCP3X08_NULL_CHECK_EN
      enerr = null_bit;
`else
      enerr = 1'b0;
`endif
      for (int s = 0; s < nscans; s++) begin
         for (int c = 0; c < nch; c++) begin
            if (!m[c]) continue;
            ech  = 3'(c);
            ecmd = 32'({1'b1, ~df, ech}) << (fl - 5);
            edat = resp[d][c] & 12'((1 << w) - 1);
            chk("frame_present", frq.size() != 0, 1);
            if (frq.size() != 0) begin
               f = frq.pop_front();
               chk("mosi_cmd", f.cmd, ecmd);
               chk("sck_pulses", f.rises, fl);
               chk("cs_low_clks", f.low, 2 * cd * fl);
               if (n > 0) chk("cs_high_gap", f.gap, csh + 1);
            end
            chk("result_present", rq.size() != 0, 1);
            if (rq.size() != 0) begin
               r = rq.pop_front();
               chk("data_out", r.data, edat);
               chk("data_ch", r.ch, ech);
               chk("scan_done", r.done, c == last);
               chk("null_err", r.nerr, enerr);
            end
            n++;
         end
      end
      chk("extra_frames", frq.size(), 0);
      chk("extra_results", rq.size(), 0);
      chk("stray_strobes", stray, 0);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vec_t tv[5];
      int rd, n, last_i;
      logic [7:0] rm;
      logic rdf;

      tv[0] = '{0, 8'h04, 1'b0, 12'h2A5, 1'b0, 1, 2, 2, 12'h2A5};
      tv[1] = '{0, 8'hA1, 1'b0, 12'h3C3, 1'b1, 3, 0, 7, 12'h3C3};
      tv[2] = '{1, 8'h08, 1'b1, 12'hFFF, 1'b0, 1, 3, 3, 12'hFFF};
      tv[3] = '{1, 8'h05, 1'b1, 12'h801, 1'b1, 2, 0, 2, 12'h801};
      tv[4] = '{0, 8'h80, 1'b1, 12'h000, 1'b0, 1, 7, 7, 12'h000};

      rst = 1'b1; start = '0; scan_cont = '0; diff_mode = '0; mask_a = '0; mask_b = '0;
      for (int d = 0; d < 2; d++) for (int c = 0; c < 8; c++) resp[d][c] = '0;
      repeat (3) @(negedge clk);
      chk("rst_csn", cs_n, 2'b11);
      chk("rst_sck", sck, 2'b00);
      chk("rst_mosi", mosi, 2'b00);
      chk("rst_busy", busy, 2'b00);
      chk("rst_strobes", {dv, done, nerr}, 6'b0);
      chk("rst_data", {dout_a, dout_b, dch_a, dch_b}, 28'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Empty mask is ignored
      mask_a = 8'h00; start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("zero_mask_busy", busy[0], 0);
      chk("zero_mask_csn", cs_n[0], 1);

      for (int i = 0; i < 5; i++) begin
         for (int c = 0; c < 8; c++) resp[tv[i].d][c] = tv[i].val;
         null_bit = tv[i].nb;
         start_scan(tv[i].d, tv[i].mask, tv[i].diff, 1'b0);
         wait_idle(tv[i].d, 4000);
         chk("vec_frames", frq.size(), tv[i].frames);
         chk("vec_results", rq.size(), tv[i].frames);
         if (frq.size() != 0)
            chk("vec_first_ch", (frq[0].cmd >> (frq[0].rises - 5)) & 32'h7, tv[i].first_ch);
         if (rq.size() != 0) begin
            last_i = rq.size() - 1;
            chk("vec_data", rq[0].data, tv[i].exp_data);
            chk("vec_last_ch", rq[last_i].ch, tv[i].last_ch);
            chk("vec_last_done", rq[last_i].done, 1);
         end
         check_run(tv[i].d, tv[i].mask, tv[i].diff, 1);
      end

      // Continuous scan stopped during the second pass; mask changes and starts while busy ignored
      null_bit = 1'b0;
      for (int c = 0; c < 8; c++) resp[0][c] = 12'h100 + 12'(c * 37);
      start_scan(0, 8'h03, 1'b0, 1'b1);
      mask_a = 8'hF0;
      n = 0;
      while (rq.size() < 3 && n < 3000) begin
         @(negedge clk); n++;
         if (n == 40 || n == 700) begin
            start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
         end
      end
      chk("cont_third_result", rq.size() >= 3, 1);
      scan_cont[0] = 1'b0;
      wait_idle(0, 3000);
      repeat (40) @(negedge clk);
      check_run(0, 8'h03, 1'b0, 2);

      // Reset in the middle of a frame
      null_bit = 1'b0;
      start_scan(0, 8'h04, 1'b0, 1'b0);
      n = 0;
      while (rise_k[0] < 9 && n < 500) begin @(negedge clk); n++; end
      chk("reach_pulse9", rise_k[0] >= 9, 1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_csn", cs_n[0], 1);
      chk("midrst_sck", sck[0], 0);
      chk("midrst_busy", busy[0], 0);
      @(negedge clk); rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("midrst_no_result", rq.size(), 0);
      frq.delete();
      for (int c = 0; c < 8; c++) resp[0][c] = 12'h2A5;
      start_scan(0, 8'h04, 1'b0, 1'b0);
      wait_idle(0, 2000);
      check_run(0, 8'h04, 1'b0, 1);

      // Randomized scans against the reference
      for (int it = 0; it < 12; it++) begin
         rd  = $urandom_range(0, 1);
         rm  = 8'($urandom_range(1, 255));
         if (rd == 1) rm = {4'h0, rm[3:0]};
         if (rm == 8'h00) rm = 8'h01;
         rdf = 1'($urandom_range(0, 1));
         null_bit = 1'($urandom_range(0, 1));
         for (int c = 0; c < 8; c++) resp[rd][c] = 12'($urandom);
         start_scan(rd, rm, rdf, 1'b0);
         wait_idle(rd, 4000);
         check_run(rd, rm, rdf, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
